// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle ARM control unit.
package arm_ctrl_pkg;

  localparam int COND_W = 4;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // ARM condition evaluation against an NZCV vector; 1111 is treated as never.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, ok;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = ~z;
      COND_CS: ok = c;
      COND_CC: ok = ~c;
      COND_MI: ok = n;
      COND_PL: ok = ~n;
      COND_VS: ok = v;
      COND_VC: ok = ~v;
      COND_HI: ok = c & ~z;
      COND_LS: ok = ~c | z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = ~z & (n == v);
      COND_LE: ok = z | (n != v);
      COND_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle: IR fields and status in, control strobes out.
interface multicycle_controller_if;

  logic                            MemReady;
  logic [arm_ctrl_pkg::COND_W-1:0] Cond;
  logic [1:0]                      Op;
  logic [5:0]                      Funct;
  logic [3:0]                      Rd;
  logic [arm_ctrl_pkg::COND_W-1:0] ALUFlags;

  logic                            IRWrite;
  logic                            PCWrite;
  logic                            RegWrite;
  logic                            MemWrite;
  logic                            AdrSrc;
  logic                            ALUSrcA;
  logic [1:0]                      ALUSrcB;
  logic [1:0]                      ResultSrc;
  logic [1:0]                      ImmSrc;
  logic [1:0]                      RegSrc;
  logic [1:0]                      ALUControl;
  logic [arm_ctrl_pkg::COND_W-1:0] Flags;

  // Controller side
  modport master (
    input  MemReady, Cond, Op, Funct, Rd, ALUFlags,
    output IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Flags
  );

  // Datapath side
  modport slave (
    output MemReady, Cond, Op, Funct, Rd, ALUFlags,
    input  IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Flags
  );

endinterface

// File: rtl/multicycle_controller_cond_unit.sv
// NZCV flags register, condition check and the per-instruction condition latch.
module cond_unit
  import arm_ctrl_pkg::*;
#(
  parameter int COND_WIDTH = COND_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COND_WIDTH-1:0] i_cond,
  input  logic [COND_WIDTH-1:0] i_alu_flags,
  input  logic [1:0]            i_flag_w,
  input  logic                  i_flag_en,
  input  logic                  i_cond_latch,
  output logic [COND_WIDTH-1:0] o_flags,
  output logic                  o_cond_ex
);

  logic [COND_WIDTH-1:0] r_flags;
  logic                  r_cond_ex;
  logic [COND_WIDTH-1:0] w_flags_next;
  logic                  w_cond_now;

  assign w_cond_now = cond_check(i_cond, r_flags);

  // Upper pair (N,Z) follows FlagW[1], lower pair (C,V) follows FlagW[0].
  genvar gi;
  generate
    for (gi = 0; gi < COND_WIDTH; gi++) begin : g_flag_next
      assign w_flags_next[gi] = i_flag_w[gi/2] ? i_alu_flags[gi] : r_flags[gi];
    end
  endgenerate

  // Flags load at the end of an executed EXECUTE; condition sampled at the end of DECODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags   <= '0;
      r_cond_ex <= 1'b0;
    end else begin
      if (i_flag_en && r_cond_ex) r_flags <= w_flags_next;
      if (i_cond_latch)           r_cond_ex <= w_cond_now;
    end
  end

  assign o_flags   = r_flags;
  assign o_cond_ex = r_cond_ex;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute/memory/writeback.
module multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH,
  parameter int     COND_WIDTH  = COND_W
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_t                r_state;
  logic                  w_is_fetch;
  logic                  w_alu_op;
  logic                  w_reg_w;
  logic                  w_mem_w;
  logic                  w_branch;
  logic                  w_adr_src;
  logic                  w_alu_src_a;
  logic [1:0]            w_alu_src_b;
  logic [1:0]            w_result_src;
  logic [1:0]            w_imm_src;
  logic [1:0]            w_reg_src;
  logic [1:0]            w_alu_control;
  logic [1:0]            w_flag_w;
  logic                  w_rd15;
  logic                  w_pcs;
  logic                  w_cond_ex;
  logic                  w_flag_en;
  logic                  w_cond_latch;
  logic [COND_WIDTH-1:0] w_flags;

  assign w_flag_en    = (r_state == EXECUTER) || (r_state == EXECUTEI);
  assign w_cond_latch = (r_state == DECODE);

  cond_unit #(.COND_WIDTH(COND_WIDTH)) u_cond (
    .clk          (clk),
    .reset        (reset),
    .i_cond       (bus.Cond),
    .i_alu_flags  (bus.ALUFlags),
    .i_flag_w     (w_flag_w),
    .i_flag_en    (w_flag_en),
    .i_cond_latch (w_cond_latch),
    .o_flags      (w_flags),
    .o_cond_ex    (w_cond_ex)
  );

  // Instruction sequencing; memory states hold until MemReady.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RESET_STATE;
    end else begin
      case (r_state)
        FETCH:    if (bus.MemReady) r_state <= DECODE;
        DECODE: begin
          case (bus.Op)
            OP_MEM:  r_state <= MEMADR;
            OP_BR:   r_state <= BRANCH;
            OP_DP:   r_state <= bus.Funct[5] ? EXECUTEI : EXECUTER;
            default: r_state <= FETCH;
          endcase
        end
        MEMADR:   r_state <= bus.Funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:  if (bus.MemReady) r_state <= MEMWB;
        MEMWB:    r_state <= FETCH;
        // A failed-condition store never waits on memory.
        MEMWRITE: if (bus.MemReady || !w_cond_ex) r_state <= FETCH;
        EXECUTER: r_state <= ALUWB;
        EXECUTEI: r_state <= ALUWB;
        ALUWB:    r_state <= FETCH;
        BRANCH:   r_state <= FETCH;
        default:  r_state <= FETCH;
      endcase
    end
  end

  // Moore decode of datapath steering and raw (ungated) write requests.
  always_comb begin
    w_adr_src    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_result_src = 2'b00;
    w_alu_op     = 1'b0;
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_branch     = 1'b0;
    case (r_state)
      FETCH, DECODE: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
      end
      MEMADR:   w_alu_src_b = 2'b01;
      MEMREAD:  w_adr_src = 1'b1;
      MEMWB: begin
        w_result_src = 2'b01;
        w_reg_w      = 1'b1;
      end
      MEMWRITE: begin
        w_adr_src = 1'b1;
        w_mem_w   = 1'b1;
      end
      EXECUTER: w_alu_op = 1'b1;
      EXECUTEI: begin
        w_alu_src_b = 2'b01;
        w_alu_op    = 1'b1;
      end
      ALUWB:    w_reg_w = 1'b1;
      BRANCH: begin
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_branch     = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU operation and flag-write selection for data-processing execute steps.
  always_comb begin
    w_alu_control = ALU_ADD;
    w_flag_w      = 2'b00;
    if (w_alu_op) begin
      case (bus.Funct[4:1])
        4'b0100: w_alu_control = ALU_ADD;
        4'b0010: w_alu_control = ALU_SUB;
        4'b0000: w_alu_control = ALU_AND;
        4'b1100: w_alu_control = ALU_ORR;
        default: w_alu_control = ALU_ADD;
      endcase
      w_flag_w[1] = bus.Funct[0];
      w_flag_w[0] = bus.Funct[0] &
                    ((w_alu_control == ALU_ADD) || (w_alu_control == ALU_SUB));
    end
  end

  // Immediate format and register-address muxing depend only on the opcode class.
  always_comb begin
    w_imm_src = 2'b00;
    w_reg_src = 2'b00;
    case (bus.Op)
      OP_MEM: begin
        w_imm_src = 2'b01;
        w_reg_src = 2'b10;
      end
      OP_BR: begin
        w_imm_src = 2'b10;
        w_reg_src = 2'b01;
      end
      default: ;
    endcase
  end

  // Writes to R15 become PC loads; every strobe is killed while reset is held.
  assign w_is_fetch = (r_state == FETCH);
  assign w_rd15     = (bus.Rd == 4'b1111);
  assign w_pcs      = (w_rd15 & w_reg_w) | w_branch;

  assign bus.IRWrite    = reset & w_is_fetch & bus.MemReady;
  assign bus.PCWrite    = reset & ((w_is_fetch & bus.MemReady) | (w_pcs & w_cond_ex));
  assign bus.RegWrite   = reset & w_reg_w & w_cond_ex & ~w_rd15;
  assign bus.MemWrite   = reset & w_mem_w & w_cond_ex;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.ALUSrcA    = w_alu_src_a;
  assign bus.ALUSrcB    = w_alu_src_b;
  assign bus.ResultSrc  = w_result_src;
  assign bus.ImmSrc     = w_imm_src;
  assign bus.RegSrc     = w_reg_src;
  assign bus.ALUControl = w_alu_control;
  assign bus.Flags      = w_flags;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction table, async reset abort, random instructions.
module tb_multicycle_controller;

  logic clk;
  logic reset;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step names used by the reference model
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4;
  localparam int P_MW = 5, P_EXR = 6, P_EXI = 7, P_AWB = 8, P_BR = 9;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    int         stall_f;
    int         stall_m;
    int         exp_regw;
    int         exp_pcw;
    int         exp_memw;
    logic [3:0] exp_flags;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [3:0] m_flags;
  logic [5:0] mux_exp [10];
  logic [5:0] mux_msk [10];
  vec_t       vecs [14];
  logic [3:0] alu_codes [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input logic [31:0] mask);
    if (mask != 32'd0) begin
      n_checks++;
      if ((act & mask) !== (exp & mask)) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act & mask, exp & mask);
      end
    end
  endtask

  // ARM condition rule: pairs of codes share a test, odd code inverts it.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cf;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cf && !z;
      3'd5:    r = (n == v);
      3'd6:    r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return !c[0];
    return c[0] ? !r : r;
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] code);
    if (code == 4'b0010) return 2'b01;
    if (code == 4'b0000) return 2'b10;
    if (code == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  function automatic vec_t mk(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                              input logic [3:0] rd, input logic [3:0] af, input int sf, input int sm,
                              input int erw, input int epc, input int emw, input logic [3:0] efl);
    vec_t v;
    v.cond = cond; v.op = op; v.funct = funct; v.rd = rd; v.alu_flags = af;
    v.stall_f = sf; v.stall_m = sm;
    v.exp_regw = erw; v.exp_pcw = epc; v.exp_memw = emw; v.exp_flags = efl;
    return v;
  endfunction

  // Runs one instruction from FETCH back to FETCH, checking every cycle against the model.
  // Entered and left just after a rising edge.
  task automatic run_instr(input vec_t v, output int regw_n, output int pcw_n, output int memw_n);
    int         ph[$];
    bit         rdy[$];
    bit         cex, rd15, e_irw, e_pcw, e_regw, e_memw, is_ex, is_wb;
    int         p;
    logic [1:0] e_ctrl;
    logic [3:0] is_exp, is_msk;
    logic [1:0] ctrl_msk;
    regw_n = 0; pcw_n = 0; memw_n = 0;
    cex  = cond_holds(v.cond, m_flags);
    rd15 = (v.rd == 4'hF);
    for (int i = 0; i < v.stall_f; i++) begin ph.push_back(P_F); rdy.push_back(1'b0); end
    ph.push_back(P_F); rdy.push_back(1'b1);
    ph.push_back(P_D); rdy.push_back(1'($urandom_range(0, 1)));
    case (v.op)
      2'd0: begin
        ph.push_back(v.funct[5] ? P_EXI : P_EXR); rdy.push_back(1'($urandom_range(0, 1)));
        ph.push_back(P_AWB); rdy.push_back(1'($urandom_range(0, 1)));
      end
      2'd1: begin
        ph.push_back(P_MA); rdy.push_back(1'($urandom_range(0, 1)));
        if (v.funct[0]) begin
          for (int i = 0; i < v.stall_m; i++) begin ph.push_back(P_MR); rdy.push_back(1'b0); end
          ph.push_back(P_MR); rdy.push_back(1'b1);
          ph.push_back(P_MWB); rdy.push_back(1'($urandom_range(0, 1)));
        end else if (cex) begin
          for (int i = 0; i < v.stall_m; i++) begin ph.push_back(P_MW); rdy.push_back(1'b0); end
          ph.push_back(P_MW); rdy.push_back(1'b1);
        end else begin
          ph.push_back(P_MW); rdy.push_back(1'($urandom_range(0, 1)));
        end
      end
      2'd2: begin
        ph.push_back(P_BR); rdy.push_back(1'($urandom_range(0, 1)));
      end
      default: ;
    endcase
    case (v.op)
      2'd0: begin is_exp = 4'b0000; is_msk = 4'b1101; end
      2'd1: begin is_exp = 4'b0110; is_msk = 4'b1111; end
      2'd2: begin is_exp = 4'b1001; is_msk = 4'b1101; end
      default: begin is_exp = 4'b0000; is_msk = 4'b0000; end
    endcase
    bus.Cond = v.cond; bus.Op = v.op; bus.Funct = v.funct; bus.Rd = v.rd;
    bus.ALUFlags = v.alu_flags;
    for (int k = 0; k < ph.size(); k++) begin
      p = ph[k];
      bus.MemReady = rdy[k];
      @(negedge clk);
      is_ex  = (p == P_EXR) || (p == P_EXI);
      is_wb  = (p == P_AWB) || (p == P_MWB);
      e_irw  = (p == P_F) && rdy[k];
      e_pcw  = e_irw || (is_wb && rd15 && cex) || ((p == P_BR) && cex);
      e_regw = is_wb && cex && !rd15;
      e_memw = (p == P_MW) && cex;
      e_ctrl = is_ex ? alu_of(v.funct[4:1]) : 2'b00;
      ctrl_msk = (is_ex || p == P_F || p == P_MA) ? 2'b11 : 2'b00;
      chk("strobes", {28'd0, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite},
          {28'd0, e_irw, e_pcw, e_regw, e_memw}, 32'hF);
      chk("muxes", {26'd0, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc},
          {26'd0, mux_exp[p]}, {26'd0, mux_msk[p]});
      chk("alu_control", {30'd0, bus.ALUControl}, {30'd0, e_ctrl}, {30'd0, ctrl_msk});
      chk("imm_reg_src", {28'd0, bus.ImmSrc, bus.RegSrc}, {28'd0, is_exp}, {28'd0, is_msk});
      chk("flags", {28'd0, bus.Flags}, {28'd0, m_flags}, 32'hF);
      regw_n += int'(bus.RegWrite);
      pcw_n  += int'(bus.PCWrite);
      memw_n += int'(bus.MemWrite);
      @(posedge clk);
      #1;
      cyc++;
      if (is_ex && cex && v.funct[0]) begin
        m_flags[3:2] = v.alu_flags[3:2];
        if (alu_of(v.funct[4:1]) == 2'b00 || alu_of(v.funct[4:1]) == 2'b01)
          m_flags[1:0] = v.alu_flags[1:0];
      end
    end
  endtask

  initial begin
    int   rw, pw, mw;
    vec_t rv;

    mux_exp[P_F]   = 6'b0_1_10_10; mux_msk[P_F]   = 6'b1_1_11_11;
    mux_exp[P_D]   = 6'b0_1_10_10; mux_msk[P_D]   = 6'b0_1_11_11;
    mux_exp[P_MA]  = 6'b0_0_01_00; mux_msk[P_MA]  = 6'b0_1_11_00;
    mux_exp[P_MR]  = 6'b1_0_00_00; mux_msk[P_MR]  = 6'b1_0_00_00;
    mux_exp[P_MWB] = 6'b0_0_00_01; mux_msk[P_MWB] = 6'b0_0_00_11;
    mux_exp[P_MW]  = 6'b1_0_00_00; mux_msk[P_MW]  = 6'b1_0_00_00;
    mux_exp[P_EXR] = 6'b0_0_00_00; mux_msk[P_EXR] = 6'b0_1_11_00;
    mux_exp[P_EXI] = 6'b0_0_01_00; mux_msk[P_EXI] = 6'b0_1_11_00;
    mux_exp[P_AWB] = 6'b0_0_00_00; mux_msk[P_AWB] = 6'b0_0_00_11;
    mux_exp[P_BR]  = 6'b0_0_01_10; mux_msk[P_BR]  = 6'b0_1_11_11;
    alu_codes[0] = 4'b0100; alu_codes[1] = 4'b0010;
    alu_codes[2] = 4'b0000; alu_codes[3] = 4'b1100;

    //           cond   op     funct       rd     aluflg sf sm  regw pcw memw flags
    vecs[0]  = mk(4'hE, 2'd0, 6'b001000, 4'd1,  4'h0, 0, 0, 1, 1, 0, 4'h0); // ADD
    vecs[1]  = mk(4'hE, 2'd1, 6'b011001, 4'd2,  4'h0, 1, 3, 1, 1, 0, 4'h0); // LDR, 3 wait cycles
    vecs[2]  = mk(4'h0, 2'd1, 6'b011000, 4'd5,  4'h0, 0, 2, 0, 1, 0, 4'h0); // STREQ, Z=0
    vecs[3]  = mk(4'hE, 2'd0, 6'b000101, 4'd3,  4'h6, 0, 0, 1, 1, 0, 4'h6); // SUBS -> Z,C
    vecs[4]  = mk(4'h0, 2'd0, 6'b001000, 4'd4,  4'hF, 0, 0, 1, 1, 0, 4'h6); // ADDEQ taken
    vecs[5]  = mk(4'hE, 2'd2, 6'b100000, 4'd0,  4'h0, 0, 0, 0, 2, 0, 4'h6); // B
    vecs[6]  = mk(4'hE, 2'd0, 6'b001000, 4'd15, 4'h0, 0, 0, 0, 2, 0, 4'h6); // ADD PC
    vecs[7]  = mk(4'hE, 2'd1, 6'b011000, 4'd5,  4'h0, 0, 2, 0, 1, 3, 4'h6); // STR, 2 wait cycles
    vecs[8]  = mk(4'h1, 2'd0, 6'b111001, 4'd6,  4'h8, 0, 0, 0, 1, 0, 4'h6); // ORRSNE skipped
    vecs[9]  = mk(4'hE, 2'd0, 6'b000001, 4'd7,  4'hB, 0, 0, 1, 1, 0, 4'hA); // ANDS: NZ only
    vecs[10] = mk(4'hE, 2'd3, 6'b000000, 4'd0,  4'h0, 2, 0, 0, 1, 0, 4'hA); // Op 11
    vecs[11] = mk(4'hA, 2'd0, 6'b001001, 4'd8,  4'h5, 0, 0, 0, 1, 0, 4'hA); // ADDSGE skipped
    vecs[12] = mk(4'hE, 2'd1, 6'b011001, 4'd15, 4'h0, 0, 1, 0, 2, 0, 4'hA); // LDR PC
    vecs[13] = mk(4'hB, 2'd0, 6'b001001, 4'd9,  4'h3, 0, 0, 1, 1, 0, 4'h3); // ADDSLT taken

    // Reset state: strobes held low even with MemReady high
    reset = 1'b0;
    bus.MemReady = 1'b1; bus.Cond = 4'hE; bus.Op = 2'd0; bus.Funct = 6'd0;
    bus.Rd = 4'd0; bus.ALUFlags = 4'hF;
    m_flags = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset_strobes", {28'd0, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite}, 32'd0, 32'hF);
    chk("reset_flags", {28'd0, bus.Flags}, 32'd0, 32'hF);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int t = 0; t < 14; t++) begin
      run_instr(vecs[t], rw, pw, mw);
      chk("regwrite_cycles", 32'(rw), 32'(vecs[t].exp_regw), 32'hFFFFFFFF);
      chk("pcwrite_cycles", 32'(pw), 32'(vecs[t].exp_pcw), 32'hFFFFFFFF);
      chk("memwrite_cycles", 32'(mw), 32'(vecs[t].exp_memw), 32'hFFFFFFFF);
      chk("flags_after", {28'd0, bus.Flags}, {28'd0, vecs[t].exp_flags}, 32'hF);
      $display("txn %0d cond=%h op=%0d funct=%b rd=%0d regw=%0d pcw=%0d memw=%0d flags=%b",
               t, vecs[t].cond, vecs[t].op, vecs[t].funct, vecs[t].rd, rw, pw, mw, bus.Flags);
    end

    // Reset during a MEMWRITE stall aborts the store at once
    bus.Cond = 4'hE; bus.Op = 2'd1; bus.Funct = 6'b011000; bus.Rd = 4'd5;
    bus.MemReady = 1'b1;
    @(posedge clk); #1;                 // FETCH -> DECODE
    bus.MemReady = 1'b0;
    @(posedge clk); #1;                 // DECODE -> MEMADR
    @(posedge clk); #1;                 // MEMADR -> MEMWRITE
    @(negedge clk);
    chk("memwrite_stall", {31'd0, bus.MemWrite}, 32'd1, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("memwrite_stall_hold", {31'd0, bus.MemWrite}, 32'd1, 32'h1);
    #2;
    reset = 1'b0;
    bus.MemReady = 1'b1;
    #1;
    chk("reset_abort_strobes", {28'd0, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite}, 32'd0, 32'hF);
    chk("reset_abort_flags", {28'd0, bus.Flags}, 32'd0, 32'hF);
    m_flags = 4'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.MemReady = 1'b0;
    @(negedge clk);
    chk("post_reset_strobes", {28'd0, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite}, 32'd0, 32'hF);
    chk("post_reset_fetch", {26'd0, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc},
        {26'd0, mux_exp[P_F]}, 32'h3F);
    @(posedge clk); #1;
    $display("txn reset-abort flags=%b", bus.Flags);

    // Random instructions against the model
    for (int t = 0; t < 60; t++) begin
      rv.cond = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      rv.op   = 2'($urandom_range(0, 3));
      if (rv.op == 2'd0)
        rv.funct = {1'($urandom_range(0, 1)), alu_codes[$urandom_range(0, 3)], 1'($urandom_range(0, 1))};
      else
        rv.funct = 6'($urandom_range(0, 63));
      rv.rd        = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      rv.alu_flags = 4'($urandom_range(0, 15));
      rv.stall_f   = int'($urandom_range(0, 2));
      rv.stall_m   = int'($urandom_range(0, 3));
      rv.exp_regw = 0; rv.exp_pcw = 0; rv.exp_memw = 0; rv.exp_flags = 4'h0;
      run_instr(rv, rw, pw, mw);
      $display("txn rnd%0d cond=%h op=%0d funct=%b rd=%0d regw=%0d pcw=%0d memw=%0d flags=%b",
               t, rv.cond, rv.op, rv.funct, rv.rd, rw, pw, mw, bus.Flags);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle ARMv4 core. It sequences the shared datapath (one ALU, one unified memory port, instruction register) through fetch, decode, execute, memory and writeback steps. It also owns the NZCV flags register and condition check, and stalls on a memory ready handshake. Instruction fields come from the datapath IR and are valid from DECODE onward.

Parameters:
RESET_STATE, FETCH, state entered on reset
COND_WIDTH, 4, width of condition and flag fields

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
MemReady  in  1  memory completes the current read or write this cycle
Cond  in  4  IR[31:28]
Op  in  2  IR[27:26]
Funct  in  6  IR[25:20]
Rd  in  4  IR[15:12]
ALUFlags  in  4  NZCV from the ALU, current cycle
IRWrite  out  1  load instruction register
PCWrite  out  1  load PC
RegWrite  out  1  register file write enable
MemWrite  out  1  memory write strobe
AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
ALUSrcA  out  1  0 = register A, 1 = PC
ALUSrcB  out  2  00 = reg B, 01 = ExtImm, 10 = constant 4
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU result
ImmSrc  out  2  00 = 8-bit rot, 01 = 12-bit, 10 = 24-bit branch
RegSrc  out  2  register-address muxing (bit0 = PC for Rn, bit1 = Rd for Rm)
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
Flags  out  4  current NZCV register (for debug/trace)

Behaviour:
- Reset (reset = 0, async): state goes to FETCH; Flags = 0000; cond_ex_q = 0. While reset is low, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0.
- State register updates on the rising edge of clk. Outputs are a Moore decode of state, gated as below.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10. IRWrite and PCWrite equal MemReady. Stay in FETCH while MemReady=0; go to DECODE on MemReady=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 for R15 reads). Latch cond_ex_q = CondEx(Cond, Flags) at the end of this cycle. Next state by Op:
  - Op 01: MEMADR.
  - Op 10: BRANCH.
  - Op 00 with Funct[5]=1: EXECUTEI.
  - Op 00 with Funct[5]=0: EXECUTER.
  - Op 11: FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Next state is MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1. Stay until MemReady=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegW=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemW=1. Stay until MemReady=1, then go to FETCH. If cond_ex_q=0, go straight to FETCH without a strobe.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1, then ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1, then ALUWB.
- ALUWB: ResultSrc=00, RegW=1, then FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, then FETCH.
- Static decode by Op: ImmSrc = 00/01/10 and RegSrc = x0/10/x1 for Op 00/01/10.
- ALU decode (ALUOp=1), by Funct[4:1]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; all other codes give ADD.
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & (ADD | SUB).
  - With ALUOp=0: ALUControl = 00 and FlagW = 00.
- Gating:
  - PCS = ((Rd == 1111) & RegW) | Branch.
  - RegWrite = RegW & cond_ex_q.
  - MemWrite = MemW & cond_ex_q.
  - PCWrite = FETCH write, or PCS & cond_ex_q in ALUWB, MEMWB or BRANCH.
  - For an R15 destination, RegWrite is suppressed and PCWrite is taken instead.
- Flags register:
  - Updated on the clock edge that ends EXECUTER or EXECUTEI, only when cond_ex_q = 1.
  - FlagW[1] loads N and Z; FlagW[0] loads C and V, from ALUFlags.
  - Because condition evaluation uses cond_ex_q latched in DECODE, a flag update in EXECUTE does not alter the writeback of the same instruction.
- Condition codes:
  - Standard ARM 0000–1101 (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE).
  - 1110 AL gives 1.
  - 1111 gives 0 (treated as never).
- MemReady held at 0 stalls indefinitely in FETCH, MEMREAD or MEMWRITE. Outputs stay stable during a stall; MemWrite stays high across the stall.
- Reset asserted mid-instruction aborts immediately; no partial write is issued after reset falls.

Decomposition:
- Package arm_ctrl_pkg:
  - state_t enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH).
  - ALUControl constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR).
  - Condition-code constants (COND_EQ … COND_AL).
- Sub-module cond_unit: flags register, condition check and cond_ex_q latch, with clk and reset. The main module keeps the FSM and the output decode.

Test Plan:
- ADD R1 with Cond=1110, Op=00, Funct=001000, MemReady=1 → FETCH, DECODE, EXECUTER, ALUWB. RegWrite=1 in ALUWB only; ALUControl=00; 4 cycles.
- LDR with Op=01, Funct=011001 and MemReady low for 3 cycles in MEMREAD → MEMREAD held 4 cycles with AdrSrc=1; MEMWB asserts RegWrite=1, ResultSrc=01.
- STREQ with Flags Z=0 → MemWrite stays 0 for the whole instruction; next FETCH follows MEMWRITE.
- SUBS giving zero (ALUFlags=0110) then ADDEQ → Flags=0110 after EXECUTER; the following ADDEQ writes back (RegWrite=1).
- B with Cond=1110, Op=10 → BRANCH asserts PCWrite=1, ALUSrcB=01, ImmSrc=10. ADD with Rd=1111 → PCWrite=1 and RegWrite=0 in ALUWB.
- reset driven low during a MEMWRITE stall → MemWrite drops to 0 asynchronously; after release, state=FETCH and Flags=0000.
